// File: rtl/clock_display_if.sv
// Bundle of the time-field inputs and multiplexed seven-segment outputs
// exchanged between the clock subsystem and the display driver.
interface clock_display_if;
  logic       en;
  logic       load;
  logic [5:0] count_sec;
  logic [5:0] count_min;
  logic [5:0] count_hrs;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output en, load, count_sec, count_min, count_hrs,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  en, load, count_sec, count_min, count_hrs,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/clock_display.sv
// Six-digit multiplexed common-anode display of seconds/minutes/hours; loaded
// snapshots are held in a shadow set and only shown from the next frame on.
module clock_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic           clk,
  input  logic           reset,
  clock_display_if.slave dif
);

  localparam int               SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        digit_q, digit_d;
  logic              en_prev_q, en_prev_d;
  logic              pending_q, pending_d;
  logic [5:0]        shadow_q [3];
  logic [5:0]        shadow_d [3];
  logic [5:0]        disp_q [3];
  logic [5:0]        disp_d [3];
  logic [5:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_start_q, frame_start_d;
  logic              boundary;
  logic [5:0]        count_in [3];
  logic [6:0]        digit_seg [6];

  assign count_in[0] = dif.count_sec;
  assign count_in[1] = dif.count_min;
  assign count_in[2] = dif.count_hrs;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_d    = scan_q;
    digit_d   = digit_q;
    en_prev_d = dif.en;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    boundary  = 1'b0;

    if (dif.en) begin
      // A rising enable restarts the scan at digit 0 as a fresh frame.
      if (!en_prev_q) begin
        scan_d   = '0;
        digit_d  = 3'd0;
        boundary = 1'b1;
      end else if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        if (digit_q == 3'd5) begin
          digit_d  = 3'd0;
          boundary = 1'b1;
        end else begin
          digit_d = digit_q + 3'd1;
        end
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end else begin
      scan_d  = '0;
      digit_d = 3'd0;
    end

    if (dif.load) begin
      shadow_d  = count_in;
      pending_d = 1'b1;
    end

    if (boundary) begin
      if (dif.load) begin
        disp_d    = count_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Decode the upcoming display values so the segments line up with an/frame_start.
  for (genvar gi = 0; gi < 3; gi++) begin : g_field
    logic [3:0] tens;
    logic [3:0] ones;
    logic       over;
    assign tens = 4'(disp_d[gi] / 6'd10);
    assign ones = 4'(disp_d[gi] % 6'd10);
    assign over = disp_d[gi] > 6'd59;
    assign digit_seg[2*gi]   = over ? SEG_DASH : seg_encode(ones);
    assign digit_seg[2*gi+1] = over ? SEG_DASH : seg_encode(tens);
  end

  always_comb begin
    an_d          = 6'h3F;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    frame_start_d = boundary;
    if (dif.en) begin
      an_d[digit_d] = 1'b0;
      case (digit_d)
        3'd0:    seg_d = digit_seg[0];
        3'd1:    seg_d = digit_seg[1];
        3'd2:    seg_d = digit_seg[2];
        3'd3:    seg_d = digit_seg[3];
        3'd4:    seg_d = digit_seg[4];
        3'd5:    seg_d = digit_seg[5];
        default: seg_d = SEG_BLANK;
      endcase
      // Separators between fields blink with the seconds.
      if ((digit_d == 3'd2 || digit_d == 3'd4) && !disp_d[0][0]) begin
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q        <= '0;
      digit_q       <= 3'd0;
      en_prev_q     <= 1'b0;
      pending_q     <= 1'b0;
      shadow_q      <= '{default: '0};
      disp_q        <= '{default: '0};
      an_q          <= 6'h3F;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      scan_q        <= scan_d;
      digit_q       <= digit_d;
      en_prev_q     <= en_prev_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dif.an          = an_q;
  assign dif.seg         = seg_q;
  assign dif.dp          = dp_q;
  assign dif.frame_start = frame_start_q;

endmodule

// File: doc/clock_display.md
# clock_display

Display-side consumer of the seconds/minutes/hours counters in the clock subsystem. Takes the three 6-bit binary time fields from the up-counters, snapshots them on a load strobe, and drives a 6-digit multiplexed common-anode seven-segment display. Snapshots are applied only at frame boundaries, so a frame never mixes old and new values. Binary-to-BCD conversion, out-of-range handling and separator blinking are handled internally.

## Interface
- SCAN_DIV, 1000: clock cycles each digit is lit; legal range is 2 or more.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  display enable; 0 blanks the display and holds the scan state.
- load  in  1  single-cycle strobe; captures count_sec, count_min and count_hrs.
- count_sec  in  6  binary seconds.
- count_min  in  6  binary minutes.
- count_hrs  in  6  binary hours.
- an  out  6  active-low digit enables, one-hot-low. an[0] is sec ones, an[1] sec tens, an[2] min ones, an[3] min tens, an[4] hrs ones, an[5] hrs tens.
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_start  out  1  one-cycle pulse on the first cycle digit 0 is lit.

## Operation
- **Reset values:** an=6'h3F, seg=7'h7F, dp=1, frame_start=0. Scan counter, digit index, shadow registers, display registers and the pending flag are all 0.
- **Load capture:** load=1 at a clock edge copies all three count inputs into the shadow registers and sets pending. If several loads arrive before a frame boundary, the last one wins.
- **Frame boundary:** the edge where the digit index wraps from 5 to 0, or the first edge after en rises.
  - If pending=1, the shadow registers move into the display registers and pending clears.
  - If load is also high on that edge, the current count inputs go straight into the display registers and pending stays 0.
- **Scan counter:** counts 0 to SCAN_DIV-1 while en=1. At terminal count it returns to 0 and the digit index advances, wrapping 5 to 0.
- **en=0:** an=6'h3F, seg=7'h7F, dp=1. Scan counter and digit index are held at 0. Load capture still operates.
- **Decoding:** each field is split into tens = value/10 and ones = value%10.
  - Any field above 59 displays as two dash digits (7'b0111111) in both of its positions.
  - Digits 0–9 encode as 7'b1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - No leading-zero suppression.
- **dp:** driven to 0 only while digit 2 or digit 4 is lit and the displayed seconds LSB is 0; otherwise 1.

## Timing
- an, seg, dp and frame_start are registered and change on the same edge.
- **Enable start:** en rises, then on the next edge an=6'b111110, seg shows sec ones, and frame_start=1 for one cycle.
- Each digit stays lit for exactly SCAN_DIV cycles. One frame is 6×SCAN_DIV cycles.
- frame_start repeats every 6×SCAN_DIV cycles while en=1.
- **Load to visible:**
  - At least 1 cycle for the shadow capture, plus the wait until the next frame boundary.
  - Worst case is 6×SCAN_DIV cycles.
  - If load coincides with the wrap edge, the new digit 0 shows the loaded value.
- **en falls mid-frame:** the display blanks on the next edge. A pending snapshot is kept and applied at the next frame start.
- **reset asserted mid-frame:** all outputs take their reset values immediately (asynchronous) and any pending snapshot is lost.
- **Release after reset:** with en=1, the first edge after reset is released starts a frame.

## Test plan
1. SCAN_DIV=4, reset released, en=1, no load → an steps 3E, 3D, 3B, 37, 2F, 1F, each for 4 cycles. Every digit shows "0" (seg=7'h40). frame_start pulses every 24 cycles.
2. load with sec=45, min=7, hrs=23 mid-frame → the current frame keeps its old values. The next frame shows digits 5, 4, 7, 0, 3, 2. dp=1 on all digits, because sec LSB is 1.
3. sec=58 loaded → dp=0 while an=3B and while an=2F; dp=1 on every other digit.
4. count_min=60 and count_hrs=63 loaded → digits 2–5 show seg=7'h3F (dash); the seconds digits decode normally.
5. Two loads in one frame (sec=10, then sec=20), followed by a load on the wrap edge (sec=30) → the next frame shows 30, and no further update occurs at the following boundary.
6. en=0 for 10 cycles mid-frame, then en=1; separately, reset pulsed low mid-frame → during en=0, an=3F and seg=7F. After en rises, the display restarts at digit 0 with frame_start=1. The reset pulse forces all outputs to their reset values asynchronously.
